// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives imem addresses, tracks the single
// in-flight read and buffers returned words in a 2-entry FIFO for decode.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    input  logic        fetch_ready
);

    logic [31:0] pc_r;
    logic        inflight_r;
    logic [31:0] inflight_pc_r;
    logic [31:0] fifo_instr_r [2];
    logic [31:0] fifo_pc_r    [2];
    logic [1:0]  count_r;
    logic        head_r;
    logic        tail_r;
    logic        valid_r;

    logic        pop_s;
    logic        push_s;
    logic        issue_s;
    logic [2:0]  occ_s;
    logic [1:0]  count_nxt_s;

    // Request address, handshake qualifiers and the issue decision
    always_comb begin
        imem_pc     = pc_r;
        pop_s       = 1'b0;
        push_s      = 1'b0;
        occ_s       = 3'd0;
        issue_s     = 1'b0;
        count_nxt_s = count_r;
        if (redirect_valid) begin
            imem_pc = redirect_pc;
        end else begin
            imem_pc = pc_r;
        end
        pop_s  = valid_r & fetch_ready & ~redirect_valid;
        push_s = inflight_r & ~redirect_valid;
        // Occupancy after this cycle's pop; issuing keeps it within the 2 slots
        occ_s   = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        issue_s = redirect_valid | (occ_s <= 3'd1);
        if (redirect_valid) begin
            count_nxt_s = 2'd0;
        end else begin
            count_nxt_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // Fetch PC, in-flight tracking and FIFO bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r       <= RESET_PC;
            inflight_r <= 1'b0;
            count_r    <= 2'd0;
            head_r     <= 1'b0;
            tail_r     <= 1'b0;
            valid_r    <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                pc_r <= imem_pc + 32'd1;
            end
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != 2'd0);
            if (redirect_valid) begin
                head_r <= 1'b0;
                tail_r <= 1'b0;
            end else begin
                if (push_s) begin
                    tail_r <= ~tail_r;
                end
                if (pop_s) begin
                    head_r <= ~head_r;
                end
            end
        end
    end

    // Payload storage needs no reset: entries are only read when counted valid
    always_ff @(posedge clk) begin
        if (issue_s) begin
            inflight_pc_r <= imem_pc;
        end
        if (push_s) begin
            fifo_instr_r[tail_r] <= imem_instr;
            fifo_pc_r[tail_r]    <= inflight_pc_r;
        end
    end

    assign fetch_valid = valid_r;
    assign fetch_instr = fifo_instr_r[head_r];
    assign fetch_pc    = fifo_pc_r[head_r];

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: an imem model plus a stream-level reference
// (expected next PC and restart age) checked every cycle.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'd0;

    logic        clk;
    logic        rst;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_ready;

    int err_cnt = 0;
    int chk_cnt = 0;

    fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_valid    (fetch_valid),
        .fetch_instr    (fetch_instr),
        .fetch_pc       (fetch_pc),
        .fetch_ready    (fetch_ready)
    );

    function automatic logic [31:0] imem_word(input logic [31:0] pc);
        if (pc == 32'd0) begin
            return 32'h08435555;
        end else begin
            return (pc * 32'h9E3779B1) ^ 32'h5A5A1234;
        end
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // imem: one-cycle registered read of the sampled address
    always_ff @(posedge clk) begin
        imem_instr <= imem_word(imem_pc);
    end

    // Reference: after a restart the stream is invalid for two cycles, then
    // stays valid and delivers consecutive PCs from the restart target.
    initial begin
        int          age;
        logic [31:0] exp_pc;
        bit          armed;
        bit          prev_hold;
        bit          prev_rst;
        logic [31:0] prev_imem;
        age       = 0;
        exp_pc    = RST_PC;
        armed     = 1'b0;
        prev_hold = 1'b0;
        prev_rst  = 1'b0;
        prev_imem = 32'd0;
        forever begin
            @(negedge clk);
            if (armed) begin
                check_eq("valid", {31'd0, fetch_valid}, {31'd0, (age >= 2)});
                if (age >= 2) begin
                    check_eq("fetch_pc", fetch_pc, exp_pc);
                    check_eq("fetch_instr", fetch_instr, imem_word(exp_pc));
                end
                if (rst && prev_rst && !redirect_valid) begin
                    check_eq("imem_pc_reset", imem_pc, RST_PC);
                end
                if (redirect_valid) begin
                    check_eq("imem_pc_redirect", imem_pc, redirect_pc);
                end
                if (prev_hold && !redirect_valid && !rst) begin
                    check_eq("imem_pc_hold", imem_pc, prev_imem);
                end
            end
            prev_hold = armed && !rst && !redirect_valid && (age >= 2) && !fetch_ready;
            prev_imem = imem_pc;
            prev_rst  = rst;
            if (rst) begin
                age    = 0;
                exp_pc = RST_PC;
                armed  = 1'b1;
            end else if (redirect_valid) begin
                age    = 1;
                exp_pc = redirect_pc;
            end else begin
                if ((age >= 2) && fetch_ready) begin
                    exp_pc = exp_pc + 32'd1;
                end
                if (age < 2) begin
                    age++;
                end
            end
        end
    end

    task automatic drive(input bit r, input bit rv, input logic [31:0] rp, input bit rdy, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            rst            = r;
            redirect_valid = rv;
            redirect_pc    = rp;
            fetch_ready    = rdy;
        end
    endtask

    initial begin
        bit          r;
        bit          rv;
        logic [31:0] rp;
        bit          rdy;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        fetch_ready    = 1'b1;
        drive(1'b1, 1'b0, 32'd0, 1'b1, 2);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 12);
        // stall then release
        drive(1'b0, 1'b0, 32'd0, 1'b0, 5);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 6);
        // redirect while full
        drive(1'b0, 1'b0, 32'd0, 1'b0, 4);
        drive(1'b0, 1'b1, 32'd5, 1'b0, 1);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 6);
        // redirect colliding with a handshake, then back-to-back redirects
        drive(1'b0, 1'b1, 32'd2, 1'b1, 1);
        drive(1'b0, 1'b1, 32'd6, 1'b1, 1);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 6);
        // address wrap
        drive(1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 6);
        // reset while stalled and full
        drive(1'b0, 1'b0, 32'd0, 1'b0, 4);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 6);
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 127) == 0);
            rv  = !r && ($urandom_range(0, 15) == 0);
            rp  = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFF - $urandom_range(0, 2)) : $urandom;
            rdy = ($urandom_range(0, 3) != 0);
            drive(r, rv, rp, rdy, 1);
        end
        drive(1'b0, 1'b0, 32'd0, 1'b1, 4);
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
